// File: rtl/mc_req_queue.sv
// Per-MC-port request queue: buffers ld/st requests, re-encodes them for the MC, and sequences write flushes.
// Define MC_REQ_STATS_EN to add saturating ld/st/stall statistics counters.
module mc_req_queue #(
  parameter int DEPTH       = 16,
  parameter int AFULL_SLACK = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_ld_i,
  input  logic        req_st_i,
  input  logic [63:0] req_wrd_rdctl_i,
  input  logic [47:0] req_vadr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_flush_i,
  output logic        req_stall_o,
  output logic        mc_rq_vld_o,
  output logic [2:0]  mc_rq_cmd_o,
  output logic [3:0]  mc_rq_sub_o,
  output logic [1:0]  mc_rq_len_o,
  output logic [47:0] mc_rq_vadr_o,
  output logic [31:0] mc_rq_rtnctl_o,
  output logic [63:0] mc_rq_data_o,
  output logic        mc_rq_flush_o,
  input  logic        mc_rq_stall_i,
  input  logic        mc_rs_flush_cmplt_i,
  output logic        flush_done_o,
  output logic        idle_o,
  output logic        err_ovf_o
`ifdef MC_REQ_STATS_EN
  ,
  output logic [31:0] stat_ld_cnt_o,
  output logic [31:0] stat_st_cnt_o,
  output logic [31:0] stat_stall_cyc_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - AFULL_SLACK);

  typedef struct packed {
    logic        is_st;
    logic [63:0] data;
    logic [47:0] vadr;
    logic [1:0]  len;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_FLUSH, S_WAIT, S_DONE} fl_state_e;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  fl_state_e       state_q, state_d;

  logic            push_req, both_req, full, pop, push;
  logic            req_stall_q, err_ovf_q;
  logic            vld_q;
  logic [2:0]      cmd_q;
  logic [1:0]      len_q;
  logic [47:0]     vadr_q;
  logic [31:0]     rtnctl_q;
  logic [63:0]     data_q;

  assign push_req = req_ld_i ^ req_st_i;
  assign both_req = req_ld_i & req_st_i;
  assign full     = (count_q == FULL_CNT);
  // Pops are frozen once the flush has been handed to the MC so nothing overtakes it.
  assign pop      = (count_q != '0) && !mc_rq_stall_i &&
                    ((state_q == S_IDLE) || (state_q == S_DRAIN));
  assign push     = push_req && (!full || pop);
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_flush_i) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !vld_q) state_d = S_FLUSH;
      S_FLUSH: if (!mc_rq_stall_i) state_d = S_WAIT;
      S_WAIT:  if (mc_rs_flush_cmplt_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{is_st: req_st_i, data: req_wrd_rdctl_i,
                                   vadr: req_vadr_i, len: req_size_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      req_stall_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      vld_q       <= 1'b0;
      cmd_q       <= '0;
      len_q       <= '0;
      vadr_q      <= '0;
      rtnctl_q    <= '0;
      data_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      state_q     <= state_d;
      req_stall_q <= (count_d >= AFULL_CNT) || (state_d != S_IDLE);
      if (both_req || (push_req && full && !pop)) err_ovf_q <= 1'b1;
      // Output fields are zeroed on non-pop cycles so cmd reads 0 when idle.
      vld_q    <= pop;
      cmd_q    <= !pop ? 3'd0 : (head.is_st ? 3'd2 : 3'd1);
      len_q    <= pop ? head.len : 2'd0;
      vadr_q   <= pop ? head.vadr : 48'd0;
      rtnctl_q <= (pop && !head.is_st) ? head.data[31:0] : 32'd0;
      data_q   <= (pop && head.is_st) ? head.data : 64'd0;
    end
  end

  assign req_stall_o    = req_stall_q;
  assign mc_rq_vld_o    = vld_q;
  assign mc_rq_cmd_o    = cmd_q;
  assign mc_rq_sub_o    = 4'd0;
  assign mc_rq_len_o    = len_q;
  assign mc_rq_vadr_o   = vadr_q;
  assign mc_rq_rtnctl_o = rtnctl_q;
  assign mc_rq_data_o   = data_q;
  assign mc_rq_flush_o  = (state_q == S_FLUSH) && !mc_rq_stall_i;
  assign flush_done_o   = (state_q == S_DONE);
  assign idle_o         = (count_q == '0) && !vld_q && (state_q == S_IDLE);
  assign err_ovf_o      = err_ovf_q;

`ifdef MC_REQ_STATS_EN
  logic [31:0] stat_ld_q, stat_st_q, stat_stall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_ld_q    <= '0;
      stat_st_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (pop && !head.is_st && (stat_ld_q != '1)) stat_ld_q <= stat_ld_q + 1'b1;
      if (pop && head.is_st && (stat_st_q != '1))  stat_st_q <= stat_st_q + 1'b1;
      if (mc_rq_stall_i && (count_q != '0) && (stat_stall_q != '1))
        stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_ld_cnt_o    = stat_ld_q;
  assign stat_st_cnt_o    = stat_st_q;
  assign stat_stall_cyc_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_mc_req_queue.sv
// Directed plus randomized bench for mc_req_queue; random phase uses a queue scoreboard and flush-ordering model.
module tb_mc_req_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_ld, req_st, req_flush;
  logic [63:0] req_wrd_rdctl;
  logic [47:0] req_vadr;
  logic [1:0]  req_size;
  logic        req_stall;
  logic        mc_rq_vld;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_sub;
  logic [1:0]  mc_rq_len;
  logic [47:0] mc_rq_vadr;
  logic [31:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;
  logic        mc_rq_flush;
  logic        mc_rq_stall;
  logic        mc_rs_flush_cmplt;
  logic        flush_done, idle, err_ovf;
`ifdef MC_REQ_STATS_EN
  logic [31:0] stat_ld_cnt, stat_st_cnt, stat_stall_cyc;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_req_queue #(.DEPTH(16), .AFULL_SLACK(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_ld_i(req_ld), .req_st_i(req_st), .req_wrd_rdctl_i(req_wrd_rdctl),
    .req_vadr_i(req_vadr), .req_size_i(req_size), .req_flush_i(req_flush),
    .req_stall_o(req_stall), .mc_rq_vld_o(mc_rq_vld), .mc_rq_cmd_o(mc_rq_cmd),
    .mc_rq_sub_o(mc_rq_sub), .mc_rq_len_o(mc_rq_len), .mc_rq_vadr_o(mc_rq_vadr),
    .mc_rq_rtnctl_o(mc_rq_rtnctl), .mc_rq_data_o(mc_rq_data), .mc_rq_flush_o(mc_rq_flush),
    .mc_rq_stall_i(mc_rq_stall), .mc_rs_flush_cmplt_i(mc_rs_flush_cmplt),
    .flush_done_o(flush_done), .idle_o(idle), .err_ovf_o(err_ovf)
`ifdef MC_REQ_STATS_EN
    , .stat_ld_cnt_o(stat_ld_cnt), .stat_st_cnt_o(stat_st_cnt), .stat_stall_cyc_o(stat_stall_cyc)
`endif
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  len;
    logic [47:0] vadr;
    logic [31:0] rtn;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  bit   fl_busy, fl_flushed, cmplt_sent, done_exp, prev_stall;
  int   fl_before, cmplt_dly;
  int   nseen;
  bit   flush_seen;
  logic [63:0] exp_s [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req_ld = 0; req_st = 0; req_flush = 0; req_wrd_rdctl = '0; req_vadr = '0; req_size = '0;
    mc_rs_flush_cmplt = 0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, 64'({req_stall, mc_rq_vld, mc_rq_cmd, mc_rq_sub, mc_rq_len,
                          mc_rq_flush, flush_done, err_ovf, idle}), 64'h1);
    chk({tag, "_vadr"}, 64'(mc_rq_vadr), 64'h0);
    chk({tag, "_rtn"}, 64'(mc_rq_rtnctl), 64'h0);
    chk({tag, "_data"}, mc_rq_data, 64'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    mc_rq_stall = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic fl_mon();
    if (mc_rq_vld) begin
      chk("t5_no_pop_after_flush", 64'(flush_seen), 64'h0);
      if (nseen < 3) chk("t5_data", mc_rq_data, exp_s[nseen]);
      nseen++;
    end
    if (mc_rq_flush) begin
      flush_seen = 1;
      chk("t5_sts_before_flush", 64'(nseen), 64'd3);
    end
  endtask

  task automatic rand_cycle(input bit active);
    bit do_push, do_st, do_flush;
    exp_t e, h;
    @(posedge clk); #1;
    do_push  = active && !req_stall && ($urandom_range(0, 2) != 0);
    do_st    = 1'($urandom_range(0, 1));
    do_flush = active && !fl_busy && ($urandom_range(0, 29) == 0);
    req_ld = do_push && !do_st;
    req_st = do_push && do_st;
    req_wrd_rdctl = {$urandom, $urandom};
    req_vadr = 48'({$urandom, $urandom});
    req_size = 2'($urandom);
    req_flush = do_flush;
    mc_rq_stall = active ? ($urandom_range(0, 3) == 0) : 1'b0;
    mc_rs_flush_cmplt = 0;
    if (fl_flushed && !cmplt_sent) begin
      if (cmplt_dly == 0) begin mc_rs_flush_cmplt = 1; cmplt_sent = 1; end
      else cmplt_dly--;
    end
    #1;
    chk("r_flush_done", 64'(flush_done), 64'(done_exp));
    if (done_exp) begin fl_busy = 0; fl_flushed = 0; cmplt_sent = 0; end
    done_exp = mc_rs_flush_cmplt;
    if (mc_rq_vld) begin
      chk("r_pop_after_stall", 64'(prev_stall), 64'h0);
      chk("r_pop_overtakes_flush", 64'(fl_busy && fl_before == 0), 64'h0);
      chk("r_sb_nonempty", 64'(sb.size() != 0), 64'h1);
      if (sb.size() != 0) begin
        h = sb.pop_front();
        chk("r_cmd_len", 64'({mc_rq_cmd, mc_rq_len, mc_rq_sub}), 64'({h.cmd, h.len, 4'h0}));
        chk("r_vadr", 64'(mc_rq_vadr), 64'(h.vadr));
        chk("r_rtnctl", 64'(mc_rq_rtnctl), 64'(h.rtn));
        chk("r_data", mc_rq_data, h.data);
      end
      if (fl_busy && fl_before > 0) fl_before--;
    end
    if (mc_rq_flush) begin
      chk("r_flush_order", 64'({fl_busy, fl_before == 0, !fl_flushed}), 64'h7);
      fl_flushed = 1;
      cmplt_dly = $urandom_range(1, 6);
    end
    if (do_push) begin
      e.cmd = do_st ? 3'd2 : 3'd1;
      e.len = req_size;
      e.vadr = req_vadr;
      e.rtn = do_st ? 32'h0 : req_wrd_rdctl[31:0];
      e.data = do_st ? req_wrd_rdctl : 64'h0;
      sb.push_back(e);
    end
    if (do_flush) begin fl_busy = 1; fl_before = sb.size(); end
    prev_stall = mc_rq_stall;
  endtask

  initial begin
    bit found;
    int vld_cnt;
`ifdef MC_REQ_STATS_EN
    logic [31:0] ld0, st0;
`endif
    // Reset state
    do_reset();
    chk_rst("reset");

    // Single load, two-cycle latency
    req_ld = 1; req_vadr = 48'h1000; req_wrd_rdctl = 64'hA5; req_size = 2'd1;
    tick();
    idle_inputs();
    chk("t1_c1_vld", 64'(mc_rq_vld), 64'h0);
    tick();
    chk("t1_c2_vld_cmd", 64'({mc_rq_vld, mc_rq_cmd}), 64'({1'b1, 3'd1}));
    chk("t1_c2_vadr", 64'(mc_rq_vadr), 64'h1000);
    chk("t1_c2_rtnctl", 64'(mc_rq_rtnctl), 64'hA5);
    chk("t1_c2_data_len", 64'({mc_rq_data[31:0], mc_rq_len}), 64'({32'h0, 2'd1}));
    tick();
    chk("t1_c3_vld_cmd_idle", 64'({mc_rq_vld, mc_rq_cmd, idle}), 64'h1);

    // Fill with stall held, overflow, then drain in order
    mc_rq_stall = 1;
    for (int i = 0; i < 16; i++) begin
      req_st = 1; req_wrd_rdctl = 64'hD000_0000_0000_0000 | 64'(i);
      req_vadr = 48'h2000 + 48'(i * 64); req_size = 2'd3;
      tick();
      chk("t2_req_stall", 64'(req_stall), 64'(i + 1 >= 12));
    end
    chk("t2_no_ovf_at_full", 64'(err_ovf), 64'h0);
    req_wrd_rdctl = 64'hFF;
    tick();
    chk("t2_ovf_17th", 64'(err_ovf), 64'h1);
    req_st = 0; mc_rq_stall = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t2_pop_vld_cmd", 64'({mc_rq_vld, mc_rq_cmd}), 64'({1'b1, 3'd2}));
      chk("t2_pop_data", mc_rq_data, 64'hD000_0000_0000_0000 | 64'(k));
      chk("t2_pop_vadr_rtn", 64'({mc_rq_vadr[15:0], mc_rq_rtnctl}), 64'({16'(16'h2000 + k * 64), 32'h0}));
    end
    tick();
    chk("t2_end_vld_stall_idle", 64'({mc_rq_vld, req_stall, idle}), 64'h1);

    // Single-cycle stall release issues exactly one request
    do_reset();
    mc_rq_stall = 1;
    for (int i = 0; i < 3; i++) begin
      req_ld = 1; req_wrd_rdctl = 64'h10 + 64'(i); req_vadr = 48'h3000 + 48'(i);
      tick();
    end
    idle_inputs();
    chk("t3_held_vld", 64'(mc_rq_vld), 64'h0);
    mc_rq_stall = 0;
    tick();
    mc_rq_stall = 1;
    chk("t3_one_pop", 64'({mc_rq_vld, mc_rq_rtnctl}), 64'({1'b1, 32'h10}));
    vld_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); vld_cnt += int'(mc_rq_vld); end
    chk("t3_no_more_pops", 64'(vld_cnt), 64'h0);
    mc_rq_stall = 0;
    tick();
    chk("t3_rest1", 64'({mc_rq_vld, mc_rq_rtnctl}), 64'({1'b1, 32'h11}));
    tick();
    chk("t3_rest2", 64'({mc_rq_vld, mc_rq_rtnctl}), 64'({1'b1, 32'h12}));

    // Flush completion ignored outside WAIT
    tick(); tick();
    mc_rs_flush_cmplt = 1;
    tick();
    mc_rs_flush_cmplt = 0;
    chk("t4_stray_cmplt", 64'({flush_done, idle}), 64'h1);

    // Three stores then flush (flush coincides with the third push)
    nseen = 0; flush_seen = 0;
    for (int i = 0; i < 3; i++) begin
      exp_s[i] = 64'h5500 + 64'(i);
      req_st = 1; req_wrd_rdctl = exp_s[i]; req_vadr = 48'h4000 + 48'(i);
      req_flush = (i == 2);
      tick();
      fl_mon();
    end
    idle_inputs();
    for (int i = 0; i < 40 && !flush_seen; i++) begin tick(); fl_mon(); end
    chk("t5_flush_seen", 64'(flush_seen), 64'h1);
    tick();
    chk("t5_flush_one_cycle", 64'({mc_rq_flush, req_stall, idle}), 64'h2);
    for (int i = 0; i < 9; i++) tick();
    chk("t5_no_early_done", 64'(flush_done), 64'h0);
    mc_rs_flush_cmplt = 1;
    tick();
    mc_rs_flush_cmplt = 0;
    chk("t5_flush_done", 64'(flush_done), 64'h1);
    tick();
    chk("t5_after_done", 64'({flush_done, idle, req_stall}), 64'h2);
    chk("t5_total_pops", 64'(nseen), 64'd3);

    // Reset while in WAIT with queued entries
    req_flush = 1;
    tick();
    req_flush = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); found = mc_rq_flush; end
    chk("t6_flush_seen", 64'(found), 64'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      req_ld = 1; req_wrd_rdctl = 64'h60 + 64'(i); req_vadr = 48'h6000;
      tick();
    end
    idle_inputs();
    chk("t6_busy_before_reset", 64'({idle, mc_rq_vld}), 64'h0);
    reset = 1;
    tick();
    chk_rst("t6_rst");
    reset = 0;
    vld_cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); vld_cnt += int'(mc_rq_vld); end
    chk("t6_no_vld_after_reset", 64'(vld_cnt), 64'h0);
    chk("t6_idle", 64'(idle), 64'h1);

    // ld and st together: nothing queued, sticky error
`ifdef MC_REQ_STATS_EN
    ld0 = stat_ld_cnt; st0 = stat_st_cnt;
`endif
    req_ld = 1; req_st = 1; req_wrd_rdctl = 64'h77;
    tick();
    idle_inputs();
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); vld_cnt += int'(mc_rq_vld); end
    chk("t7_no_issue", 64'(vld_cnt), 64'h0);
    chk("t7_err_idle", 64'({err_ovf, idle}), 64'h3);
`ifdef MC_REQ_STATS_EN
    chk("t7_stats_unchanged", {stat_ld_cnt, stat_st_cnt}, {ld0, st0});
`endif

    // Randomized traffic against the scoreboard
    do_reset();
    chk("r_err_cleared", 64'(err_ovf), 64'h0);
    sb.delete();
    fl_busy = 0; fl_flushed = 0; cmplt_sent = 0; done_exp = 0; prev_stall = 0;
    fl_before = 0; cmplt_dly = 0;
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    for (int c = 0; c < 300 && (sb.size() != 0 || fl_busy); c++) rand_cycle(1'b0);
    chk("r_drained", 64'({sb.size() == 0, fl_busy}), 64'h2);
    idle_inputs();
    tick(); tick();
    chk("r_final_idle_err", 64'({idle, err_ovf}), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
